// File: rtl/step_sequencer.sv
// Playback reader for four 12-step beat patterns: transport and tempo are decoded
// from the USB keycode bus, and each step entry fires one-cycle channel triggers.
module step_sequencer #(
  parameter int PERIOD_WIDTH   = 27,
  parameter int PERIOD_DEFAULT = 12_500_000,
  parameter int PERIOD_MIN     = 3_125_000,
  parameter int PERIOD_MAX     = 25_000_000,
  parameter int PERIOD_STEP    = 625_000
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic [11:0]             channel0,
  input  logic [11:0]             channel1,
  input  logic [11:0]             channel2,
  input  logic [11:0]             channel3,
  output logic [3:0]              trig,
  output logic                    step_strobe,
  output logic [3:0]              step,
  output logic                    playing,
  output logic [PERIOD_WIDTH-1:0] step_period
);

  localparam int PW1 = PERIOD_WIDTH + 1;
  localparam logic [PW1-1:0] MIN_W  = PW1'(PERIOD_MIN);
  localparam logic [PW1-1:0] MAX_W  = PW1'(PERIOD_MAX);
  localparam logic [PW1-1:0] STEP_W = PW1'(PERIOD_STEP);
  localparam logic [PERIOD_WIDTH-1:0] DEFAULT_P = PERIOD_WIDTH'(PERIOD_DEFAULT);

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_MINUS = 8'h2D;
  localparam logic [7:0] KEY_EQUAL = 8'h2E;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t                  state_r, state_next_s;
  logic [7:0]              prev_key_r;
  logic [PERIOD_WIDTH-1:0] tick_cnt_r, tick_cnt_next_s;
  logic [3:0]              step_next_s, step_inc_s;
  logic [3:0]              trig_next_s;
  logic                    strobe_next_s;
  logic [PERIOD_WIDTH-1:0] period_next_s;
  logic [PW1-1:0]          period_wide_s, slower_s, faster_s;
  logic                    key_event_s, space_s, enter_s, boundary_s;

  // Gather the bit at one step index from all four channels, channel n in bit n.
  function automatic logic [3:0] pattern_at(input logic [3:0] idx,
                                            input logic [11:0] c0, input logic [11:0] c1,
                                            input logic [11:0] c2, input logic [11:0] c3);
    return {c3[idx], c2[idx], c1[idx], c0[idx]};
  endfunction

  assign key_event_s = (keycode != prev_key_r) && (keycode != 8'h00);
  assign space_s     = key_event_s && (keycode == KEY_SPACE);
  assign enter_s     = key_event_s && (keycode == KEY_ENTER);
  assign boundary_s  = tick_cnt_r >= (step_period - PERIOD_WIDTH'(1));
  assign step_inc_s  = (step == 4'd11) ? 4'd0 : step + 4'd1;

  assign period_wide_s = {1'b0, step_period};
  assign slower_s      = period_wide_s + STEP_W;
  assign faster_s      = period_wide_s - STEP_W;

  // Tempo keys adjust the period with saturation at both limits.
  always_comb begin
    period_next_s = step_period;
    if (key_event_s && (keycode == KEY_MINUS)) begin
      period_next_s = (slower_s > MAX_W) ? MAX_W[PERIOD_WIDTH-1:0] : slower_s[PERIOD_WIDTH-1:0];
    end else if (key_event_s && (keycode == KEY_EQUAL)) begin
      // Compare before subtracting so a small period can never wrap.
      period_next_s = (period_wide_s < (MIN_W + STEP_W)) ? MIN_W[PERIOD_WIDTH-1:0]
                                                        : faster_s[PERIOD_WIDTH-1:0];
    end else begin
      period_next_s = step_period;
    end
  end

  // Transport state machine, step advance and trigger generation.
  always_comb begin
    state_next_s    = state_r;
    tick_cnt_next_s = tick_cnt_r;
    step_next_s     = step;
    trig_next_s     = 4'b0000;
    strobe_next_s   = 1'b0;
    case (state_r)
      STOPPED: begin
        tick_cnt_next_s = '0;
        step_next_s     = 4'd0;
        if (space_s) begin
          state_next_s  = PLAYING;
          strobe_next_s = 1'b1;
          trig_next_s   = pattern_at(4'd0, channel0, channel1, channel2, channel3);
        end else begin
          state_next_s  = STOPPED;
        end
      end
      PLAYING: begin
        if (space_s) begin
          state_next_s = PAUSED;
        end else if (enter_s) begin
          state_next_s    = STOPPED;
          tick_cnt_next_s = '0;
          step_next_s     = 4'd0;
        end else if (boundary_s) begin
          tick_cnt_next_s = '0;
          step_next_s     = step_inc_s;
          strobe_next_s   = 1'b1;
          trig_next_s     = pattern_at(step_inc_s, channel0, channel1, channel2, channel3);
        end else begin
          tick_cnt_next_s = tick_cnt_r + PERIOD_WIDTH'(1);
        end
      end
      PAUSED: begin
        if (space_s) begin
          state_next_s = PLAYING;
        end else if (enter_s) begin
          state_next_s    = STOPPED;
          tick_cnt_next_s = '0;
          step_next_s     = 4'd0;
        end else begin
          state_next_s = PAUSED;
        end
      end
      default: begin
        state_next_s    = STOPPED;
        tick_cnt_next_s = '0;
        step_next_s     = 4'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= STOPPED;
      prev_key_r  <= 8'h00;
      tick_cnt_r  <= '0;
      step        <= 4'd0;
      trig        <= 4'b0000;
      step_strobe <= 1'b0;
      playing     <= 1'b0;
      step_period <= DEFAULT_P;
    end else begin
      state_r     <= state_next_s;
      prev_key_r  <= keycode;
      tick_cnt_r  <= tick_cnt_next_s;
      step        <= step_next_s;
      trig        <= trig_next_s;
      step_strobe <= strobe_next_s;
      playing     <= (state_next_s == PLAYING);
      step_period <= period_next_s;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with a short tempo (default 8, range 4..12, step 2).
module tb_step_sequencer;

  localparam int PW = 8;

  logic          Clk;
  logic          Reset;
  logic [7:0]    keycode;
  logic [11:0]   channel0, channel1, channel2, channel3;
  logic [3:0]    trig;
  logic          step_strobe;
  logic [3:0]    step;
  logic          playing;
  logic [PW-1:0] step_period;

  int n_checks = 0;
  int n_fail   = 0;

  step_sequencer #(
    .PERIOD_WIDTH(PW), .PERIOD_DEFAULT(8), .PERIOD_MIN(4),
    .PERIOD_MAX(12), .PERIOD_STEP(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode),
    .channel0(channel0), .channel1(channel1), .channel2(channel2), .channel3(channel3),
    .trig(trig), .step_strobe(step_strobe), .step(step), .playing(playing),
    .step_period(step_period)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One key press: outputs reflect it on return, then the key is released.
  task automatic press(input logic [7:0] code);
    keycode = code;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic wait_strobe(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!step_strobe && cycles < 100);
    if (!step_strobe) check("strobe_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic wait_step(input logic [3:0] target);
    int c;
    for (int i = 0; i < 14; i++) begin
      wait_strobe(c);
      if (step == target) break;
    end
    check("reach_step", 32'(step), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_trig"}, 32'(trig), 32'd0);
    check({tag, "_strobe"}, 32'(step_strobe), 32'd0);
    check({tag, "_step"}, 32'(step), 32'd0);
    check({tag, "_playing"}, 32'(playing), 32'd0);
    check({tag, "_period"}, 32'(step_period), 32'd8);
  endtask

  initial begin
    int c, strobes, low;
    Reset = 1'b1;
    keycode = 8'h00;
    channel0 = 12'h000; channel1 = 12'h000; channel2 = 12'h000; channel3 = 12'h000;
    tick(); tick();
    Reset = 1'b0;
    tick();
    check_reset_outputs("reset");

    // Basic playback: step 0 entry, spacing, step 11 and wrap.
    channel0 = 12'h001;
    channel2 = 12'h801;
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    check("play_playing", 32'(playing), 32'd1);
    check("play_step", 32'(step), 32'd0);
    check("play_strobe", 32'(step_strobe), 32'd1);
    check("play_trig", 32'(trig), 32'b0101);
    tick();
    check("strobe_one_cycle", 32'(step_strobe), 32'd0);
    wait_strobe(c);
    check("step1_spacing", 32'(c + 1), 32'd8);
    check("step1_step", 32'(step), 32'd1);
    check("step1_trig", 32'(trig), 32'd0);
    wait_step(4'd11);
    check("step11_trig", 32'(trig), 32'b0100);
    wait_strobe(c);
    check("wrap_spacing", 32'(c), 32'd8);
    check("wrap_step", 32'(step), 32'd0);
    check("wrap_trig", 32'(trig), 32'b0101);

    // Held space from STOPPED: one start, no pause; strobes every 8 cycles.
    press(8'h28);
    check("stop_playing", 32'(playing), 32'd0);
    keycode = 8'h2C;
    strobes = 0;
    low = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (step_strobe) strobes++;
      if (!playing) low++;
    end
    keycode = 8'h00;
    check("hold_playing_low", 32'(low), 32'd0);
    check("hold_strobes", 32'(strobes), 32'd7);
    tick();

    // Pause mid-step 3 and resume.
    press(8'h28);
    press(8'h2C);
    wait_step(4'd3);
    tick(); tick();
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    check("pause_playing", 32'(playing), 32'd0);
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (step_strobe) strobes++;
    end
    check("pause_strobes", 32'(strobes), 32'd0);
    check("pause_step", 32'(step), 32'd3);
    keycode = 8'h2C;
    tick();
    keycode = 8'h00;
    check("resume_strobe", 32'(step_strobe), 32'd0);
    wait_strobe(c);
    check("resume_remaining", 32'(c), 32'd6);
    check("resume_step", 32'(step), 32'd4);

    // Tempo: faster with clamp, then slower with clamp.
    press(8'h2E);
    check("faster_1", 32'(step_period), 32'd6);
    wait_strobe(c);
    wait_strobe(c);
    check("spacing_6", 32'(c), 32'd6);
    press(8'h2E);
    check("faster_2", 32'(step_period), 32'd4);
    press(8'h2E);
    check("faster_clamp", 32'(step_period), 32'd4);
    wait_strobe(c);
    wait_strobe(c);
    check("spacing_4", 32'(c), 32'd4);
    for (int i = 0; i < 5; i++) press(8'h2D);
    check("slower_clamp", 32'(step_period), 32'd12);
    wait_strobe(c);
    wait_strobe(c);
    check("spacing_12", 32'(c), 32'd12);

    // Enter in the boundary cycle wins over the advance.
    for (int i = 0; i < 11; i++) tick();
    keycode = 8'h28;
    tick();
    keycode = 8'h00;
    check("stop_bnd_strobe", 32'(step_strobe), 32'd0);
    check("stop_bnd_trig", 32'(trig), 32'd0);
    check("stop_bnd_step", 32'(step), 32'd0);
    check("stop_bnd_playing", 32'(playing), 32'd0);
    tick();

    // Reset mid-play.
    press(8'h2C);
    tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_reset_outputs("midreset");
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step_strobe) strobes++;
    end
    check("midreset_quiet", 32'(strobes), 32'd0);

    // Live pattern edit: set ch1 bit 5 during step 4, clear it during step 5.
    press(8'h2C);
    wait_step(4'd4);
    channel1 = 12'h020;
    wait_strobe(c);
    check("edit_step5", 32'(step), 32'd5);
    check("edit_trig5", 32'(trig), 32'b0010);
    tick();
    channel1 = 12'h000;
    wait_strobe(c);
    check("edit_no_retrig", 32'(c), 32'd7);
    check("edit_step6", 32'(step), 32'd6);
    check("edit_trig6", 32'(trig), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Playback reader for the four 12-step beat patterns produced by the keyboard pattern writer. It holds a step position and a tempo counter, and reads the channel patterns at each step boundary. For every channel whose bit is set at the new step, it issues a one-cycle trigger to the sample players. Transport (play/pause/stop) and tempo come from the same USB keycode bus the pattern writer decodes; step index goes to the display logic for the playhead.

## Interface
Parameters:
- PERIOD_WIDTH, 27, width of the step-period and tick counters
- PERIOD_DEFAULT, 12_500_000, clocks per step after reset
- PERIOD_MIN, 3_125_000, lowest allowed step period (fastest tempo)
- PERIOD_MAX, 25_000_000, highest allowed step period (slowest tempo)
- PERIOD_STEP, 625_000, period change per tempo key press

Ports:
- Clk, in, 1, system clock
- Reset, in, 1, synchronous, active-high reset
- keycode, in, 8, current USB HID keycode; 0 = no key
- channel0..channel3, in, 12 each, beat patterns; bit i = step i
- trig, out, 4, one-cycle trigger pulses; bit n = channel n
- step_strobe, out, 1, one-cycle pulse when a step is entered
- step, out, 4, current step index, 0..11
- playing, out, 1, 1 only in PLAYING
- step_period, out, PERIOD_WIDTH, current clocks-per-step

## Operation
- Key edge detect: register keycode as prev_key. A key event is keycode != prev_key && keycode != 0. Only events act, so a held key acts once.
- Decoded events:
  - 8'h2C (space) toggles play/pause.
  - 8'h28 (enter) stops.
  - 8'h2D (-) adds PERIOD_STEP to step_period (slower).
  - 8'h2E (=) subtracts PERIOD_STEP from step_period (faster).
  - All other codes are ignored, including the pattern-edit and channel keys.
- Tempo: step_period saturates at PERIOD_MIN/PERIOD_MAX and never overshoots. Arithmetic is PERIOD_WIDTH+1 bits wide before the clamp.
- States:
  - STOPPED: step=0, tick_cnt=0. A space event goes to PLAYING. The step-0 entry happens on that transition: step_strobe=1, and trig = bit 0 of each channel.
  - PLAYING: tick_cnt increments each cycle. When tick_cnt >= step_period-1, tick_cnt becomes 0 and step becomes (step==11 ? 0 : step+1), with step_strobe=1 and trig[n] = channeln[new step]. A space event goes to PAUSED; an enter event goes to STOPPED.
  - PAUSED: tick_cnt and step hold, and no strobes fire. A space event goes to PLAYING and resumes counting from the held tick_cnt with no immediate trigger. An enter event goes to STOPPED.
- Patterns are read combinationally from channel0..3 in the cycle the boundary is detected. Pattern edits take effect from the next boundary; past steps are never retriggered.
- Enter in STOPPED is a no-op.

## Timing
- Reset values: state=STOPPED, step=0, tick_cnt=0, trig=0, step_strobe=0, playing=0, step_period=PERIOD_DEFAULT, prev_key=0.
- All outputs are registered.
- Key at cycle N is visible in the outputs after edge N+1.
- Play from STOPPED: key in cycle N; at N+1, playing=1, step=0, step_strobe=1, trig = patterns sampled at N.
- Step boundaries in steady state are exactly step_period cycles apart. Step 11 is followed by step 0.
- Tempo change mid-step takes effect immediately. If tick_cnt already >= new period-1, the boundary fires in the next cycle.
- Simultaneous events:
  - Reset overrides all.
  - A stop or pause event in a boundary cycle wins: no advance, no trig.
  - A tempo event in a boundary cycle applies alongside the advance.
- trig and step_strobe are never high for more than one consecutive cycle. trig is always 0 when step_strobe=0.
- Reset mid-play: next cycle is STOPPED with all outputs at reset values. No trigger fires until the next space event.

## Test plan
Bench parameters: PERIOD_DEFAULT=8, MIN=4, MAX=12, STEP=2.
- Reset, set channel0=12'h001 and channel2=12'h801, press space for 1 cycle:
  - next cycle step=0, step_strobe=1, trig=4'b0101.
  - 8 cycles later step=1, trig=0.
  - The step-11 strobe gives trig=4'b0100.
  - The following wrap to step 0 gives trig=4'b0101 again.
- Hold space for 50 cycles from STOPPED: exactly one transition to PLAYING, with no pause.
- Play, then press space at step 3 mid-step: step stays 3 and no strobes for 100 cycles. Press space again: the next strobe arrives after the remaining ticks, at step 4.
- Press = 3 times: step_period goes 8→6→4→4 (clamped). Press - 5 times: reaches 12 and holds. Boundary spacing matches each period.
- While playing, press enter in the same cycle a boundary is due: no strobe, step=0, playing=0. Then assert Reset mid-play: all outputs are at reset values next cycle.
- Change channel1 bit 5 while step=4: the step-5 strobe shows trig[1]=1. Clear it during step 5: no retrigger.
